// File: rtl/pci_pkg.sv
// Shared PCI definitions for the target and the initiator device.
// Contents:
//   pci_state_e        target FSM state encoding
//   CMD_READ/CMD_WRITE cbe command encodings sampled with the address
//   PCI_DEPTH_DEFAULT  default number of 32-bit words of target storage
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_TURN    = 3'd2,
        ST_DATA    = 3'd3,
        ST_BACKOFF = 3'd4
    } pci_state_e;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    localparam int PCI_DEPTH_DEFAULT = 10;

endpackage

// File: rtl/pci_target_if.sv
// Simplified PCI bus bundle between one initiator and the target.
// Signals:
//   frame_n, irdy_n  initiator frame / initiator ready (active-low)
//   cbe              command sampled with the address (1=read, 0=write)
//   ad_in            address/data as sampled by the target
//   ad_out, ad_oe    read data toward the bus and its enable (tri-state external)
//   devsel_n, trdy_n target device select / target ready (active-low)
// Modports: master (initiator side), slave (target side).
//
// Handshake: a data phase completes on a rising edge where both irdy_n=0 and
// trdy_n=0. Either side may hold its ready high to insert wait states; nothing
// moves while either is high. The initiator marks the last phase by driving
// frame_n=1 together with irdy_n=0; frame_n=1 with irdy_n=1 during data is an
// abort.
interface pci_target_if;
    logic        frame_n;
    logic        irdy_n;
    logic        cbe;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        devsel_n;
    logic        trdy_n;

    modport master (
        output frame_n, irdy_n, cbe, ad_in,
        input  ad_out, ad_oe, devsel_n, trdy_n
    );

    modport slave (
        input  frame_n, irdy_n, cbe, ad_in,
        output ad_out, ad_oe, devsel_n, trdy_n
    );
endinterface

// File: rtl/pci_target_mem.sv
// Target word storage: DEPTH x 32, one synchronous write port, one
// combinational read port, synchronous clear of every word.
// Ports:
//   clk    clock
//   clear  synchronous clear, takes priority over a write
//   we     write enable; waddr/wdata write port
//   raddr  read address; rdata combinational read data
module pci_target_mem #(
    parameter int DEPTH = 10,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (int'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Out-of-range addresses cannot occur from the target, but read as zero
    // rather than indexing past the array.
    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/pci_target.sv
// Simplified PCI target with DEPTH words of storage at BASE_ADDR.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   bus        pci_target_if.slave bundle (frame_n, irdy_n, cbe, ad_in in;
//              ad_out, ad_oe, devsel_n, trdy_n out; all outputs registered)
//   dbg_state  current FSM state
// Configuration:
//   PCI_TARGET_WAIT_EN  when defined, one trdy_n=1 wait cycle precedes every
//                       data phase; undefined gives zero target wait states.
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = PCI_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    pci_target_if.slave  bus,
    output pci_state_e   dbg_state
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef PCI_TARGET_WAIT_EN
    localparam logic TGT_WAIT = 1'b1;
`else
    localparam logic TGT_WAIT = 1'b0;
`endif

    pci_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          cmd_q, cmd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          devsel_n_q, devsel_n_d;
    logic          trdy_n_q, trdy_n_d;
    logic          ad_oe_q, ad_oe_d;
    logic [31:0]   ad_out_q, ad_out_d;

    logic [31:0]   offset;
    logic          hit;
    logic [IW-1:0] idx_inc;
    logic          phase_done;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_data;
    logic          mem_we;

    // Offset form of the range check so BASE_ADDR+DEPTH cannot overflow.
    assign offset     = addr_q - BASE_ADDR;
    assign hit        = (addr_q >= BASE_ADDR) && (offset < DEPTH_W);
    assign idx_inc    = (idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + IW'(1);
    assign phase_done = (state_q == ST_DATA) && !bus.irdy_n && !trdy_n_q;

    // In DATA the read port looks one word ahead so ad_out can advance on the
    // completing edge; in TURN it fetches the first word.
    assign rd_idx = (state_q == ST_DATA) ? idx_inc : idx_q;
    assign mem_we = phase_done && (cmd_q == CMD_WRITE);

    pci_target_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .clear (reset),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (bus.ad_in),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        devsel_n_d = devsel_n_q;
        trdy_n_d   = trdy_n_q;
        ad_oe_d    = ad_oe_q;
        ad_out_d   = ad_out_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.frame_n) begin
                    addr_d  = bus.ad_in;
                    cmd_d   = bus.cbe;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (hit) begin
                    idx_d      = offset[IW-1:0];
                    devsel_n_d = 1'b0;
                    if (cmd_q == CMD_WRITE) begin
                        trdy_n_d = TGT_WAIT;
                        state_d  = ST_DATA;
                    end else begin
                        state_d  = ST_TURN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                ad_oe_d  = 1'b1;
                ad_out_d = rd_data;
                trdy_n_d = TGT_WAIT;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (phase_done) begin
                    idx_d = idx_inc;
                    if (bus.frame_n) begin
                        state_d    = ST_BACKOFF;
                        devsel_n_d = 1'b1;
                        trdy_n_d   = 1'b1;
                        ad_oe_d    = 1'b0;
                        ad_out_d   = '0;
                    end else begin
                        trdy_n_d = TGT_WAIT;
                        if (cmd_q == CMD_READ) begin
                            ad_out_d = rd_data;
                        end
                    end
                end else if (bus.frame_n && bus.irdy_n) begin
                    state_d    = ST_BACKOFF;
                    devsel_n_d = 1'b1;
                    trdy_n_d   = 1'b1;
                    ad_oe_d    = 1'b0;
                    ad_out_d   = '0;
                end else if (trdy_n_q) begin
                    // End of a target wait cycle.
                    trdy_n_d = 1'b0;
                end
            end
            ST_BACKOFF: begin
                // Outputs are already inactive; a new frame here is ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cmd_q      <= CMD_WRITE;
            idx_q      <= '0;
            devsel_n_q <= 1'b1;
            trdy_n_q   <= 1'b1;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            devsel_n_q <= devsel_n_d;
            trdy_n_q   <= trdy_n_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
        end
    end

    assign bus.devsel_n = devsel_n_q;
    assign bus.trdy_n   = trdy_n_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_out   = ad_out_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pci_target.sv
module tb_pci_target;
    import pci_pkg::*;

    localparam int DEPTH = PCI_DEPTH_DEFAULT;

`ifdef PCI_TARGET_WAIT_EN
    localparam logic [31:0] EXP_WAIT = 32'd1;
`else
    localparam logic [31:0] EXP_WAIT = 32'd0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pci_target_if bus ();
    pci_state_e   dbg_state;

    pci_target #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q [$];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] wdata [8];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    // ---------------- driver tasks ----------------
    // One burst at a hit address. stall_at: after that many completed phases
    // the initiator holds irdy_n high for two cycles (junk on ad_in).
    // rst_at: reset fires on the edge that would complete that phase.
    // poke: drive a new frame during BACKOFF, which must be ignored.
    task automatic run_burst(input logic [31:0] addr, input logic cmd, input int n,
                             input int stall_at, input int rst_at, input bit poke);
        int  phase, obs, stall_left, base;
        bit  complete, prev_c, rst_fire;
        base = int'(addr) % DEPTH;
        phase = 0; obs = 0; stall_left = 0; prev_c = 0; rst_fire = 0;
        @(posedge clk); #1;
        bus.frame_n = 1'b0; bus.cbe = cmd; bus.ad_in = addr; bus.irdy_n = 1'b1;
        if (cmd == CMD_READ)
            for (int i = 0; i < n; i++) exp_q.push_back(exp_mem[(base + i) % DEPTH]);
        @(posedge clk); #1;
        bus.ad_in   = (cmd == CMD_WRITE) ? wdata[0] : 32'h0;
        bus.irdy_n  = 1'b0;
        bus.frame_n = (n == 1);
        while (phase < n && obs < 40) begin
            @(negedge clk);
            complete = !bus.trdy_n && !bus.irdy_n;
            if (obs == 0) check("st_decode", 32'(dbg_state), 32'(ST_DECODE));
            if (obs == 1) begin
                check("st_first", 32'(dbg_state), (cmd == CMD_READ) ? 32'(ST_TURN) : 32'(ST_DATA));
                check("oe_early", 32'(bus.ad_oe), 32'd0);
                check("devsel_early", 32'(bus.devsel_n), 32'd0);
            end
            if (prev_c) check("trdy_after_phase", 32'(bus.trdy_n), EXP_WAIT);
            if (stall_left > 0 && cmd == CMD_READ && exp_q.size() > 0) begin
                check("hold_dout", bus.ad_out, exp_q[0]);
                if (EXP_WAIT == 0) check("hold_trdy", 32'(bus.trdy_n), 32'd0);
            end
            if (complete) begin
                check("devsel", 32'(bus.devsel_n), 32'd0);
                if (phase == rst_at) begin
                    reset = 1'b1;
                    complete = 0;
                    rst_fire = 1;
                end else if (cmd == CMD_READ) begin
                    check("oe_data", 32'(bus.ad_oe), 32'd1);
                    if (exp_q.size() == 0) check("rdata_extra", 32'd1, 32'd0);
                    else check("rdata", bus.ad_out, exp_q.pop_front());
                end
            end
            @(posedge clk); #1;
            if (rst_fire) begin
                reset = 1'b0;
                bus.frame_n = 1'b1; bus.irdy_n = 1'b1; bus.ad_in = '0;
                clear_model();
                break;
            end
            if (complete) begin
                if (cmd == CMD_WRITE) exp_mem[(base + phase) % DEPTH] = wdata[phase];
                phase++;
                if (phase == n) begin
                    bus.frame_n = 1'b1; bus.irdy_n = 1'b1; bus.ad_in = '0;
                end else if (phase == stall_at) begin
                    bus.irdy_n = 1'b1; stall_left = 2; bus.ad_in = 32'hDEAD_BEEF;
                end else begin
                    bus.ad_in = (cmd == CMD_WRITE) ? wdata[phase] : 32'h0;
                    bus.frame_n = (phase == n - 1);
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    bus.irdy_n = 1'b0;
                    bus.ad_in = (cmd == CMD_WRITE) ? wdata[phase] : 32'h0;
                    bus.frame_n = (phase == n - 1);
                end
            end
            prev_c = complete && (phase < n);
            obs++;
        end
        if (rst_fire) begin
            @(negedge clk);
            check("rst_devsel", 32'(bus.devsel_n), 32'd1);
            check("rst_trdy", 32'(bus.trdy_n), 32'd1);
            check("rst_oe", 32'(bus.ad_oe), 32'd0);
            check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
            exp_q.delete();
        end else if (phase < n) begin
            check("burst_timeout", 32'(phase), 32'(n));
            bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
            exp_q.delete();
            repeat (3) @(posedge clk);
        end else begin
            if (poke) begin
                bus.frame_n = 1'b0; bus.cbe = CMD_READ; bus.ad_in = addr;
            end
            @(negedge clk);
            check("backoff_state", 32'(dbg_state), 32'(ST_BACKOFF));
            check("backoff_devsel", 32'(bus.devsel_n), 32'd1);
            check("backoff_trdy", 32'(bus.trdy_n), 32'd1);
            check("backoff_oe", 32'(bus.ad_oe), 32'd0);
            @(posedge clk); #1;
            bus.frame_n = 1'b1;
            @(negedge clk);
            check("idle_after_backoff", 32'(dbg_state), 32'(ST_IDLE));
        end
    endtask

    task automatic miss_frame(input logic [31:0] addr);
        @(posedge clk); #1;
        bus.frame_n = 1'b0; bus.cbe = CMD_WRITE; bus.ad_in = addr; bus.irdy_n = 1'b1;
        @(posedge clk); #1;
        bus.irdy_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("miss_devsel", 32'(bus.devsel_n), 32'd1);
            check("miss_trdy", 32'(bus.trdy_n), 32'd1);
            @(posedge clk); #1;
        end
        bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        bus.frame_n = 1'b1; bus.irdy_n = 1'b1; bus.cbe = CMD_WRITE; bus.ad_in = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_devsel", 32'(bus.devsel_n), 32'd1);
        check("reset_trdy", 32'(bus.trdy_n), 32'd1);
        check("reset_oe", 32'(bus.ad_oe), 32'd0);
        check("reset_dout", bus.ad_out, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
        run_burst(32'd0, CMD_WRITE, 4, -1, -1, 1'b0);
        run_burst(32'd2, CMD_READ, 3, -1, -1, 1'b0);
        miss_frame(32'h0000_0020);
        run_burst(32'd0, CMD_READ, 4, 2, -1, 1'b0);

        wdata[0] = 32'd1; wdata[1] = 32'd2;
        run_burst(32'd9, CMD_WRITE, 2, -1, -1, 1'b1);
        run_burst(32'd9, CMD_READ, 2, -1, -1, 1'b0);

        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33;
        run_burst(32'd5, CMD_WRITE, 3, 1, -1, 1'b0);
        run_burst(32'd5, CMD_READ, 3, 1, -1, 1'b0);

        wdata[0] = 32'h55; wdata[1] = 32'h66;
        run_burst(32'd5, CMD_WRITE, 2, -1, 1, 1'b0);
        @(posedge clk); #1;
        run_burst(32'd4, CMD_READ, 3, -1, -1, 1'b0);
        run_burst(32'd0, CMD_READ, 1, -1, -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            int n;
            a = 32'($urandom_range(0, DEPTH - 1));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wdata[i] = $urandom;
            run_burst(a, CMD_WRITE, n, (k == 1) ? 1 : -1, -1, 1'b0);
            run_burst(a, CMD_READ, n, (k == 2) ? 1 : -1, -1, 1'b0);
        end

        if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first bus address claimed by the target.
REQ-002 SHALL have parameter DEPTH, default 10, number of 32-bit words of target storage.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 frame_n  in  1  initiator frame, active-low.
REQ-006 irdy_n  in  1  initiator ready, active-low.
REQ-007 cbe  in  1  command, sampled with address: 1=read, 0=write.
REQ-008 ad_in  in  32  sampled address/data bus.
REQ-009 ad_out  out  32  read data driven toward bus.
REQ-010 ad_oe  out  1  ad_out enable; bus tri-state is external.
REQ-011 devsel_n  out  1  device select, active-low.
REQ-012 trdy_n  out  1  target ready, active-low.

Function
REQ-013 SHALL implement states IDLE, DECODE, TURN, DATA, BACKOFF; all outputs registered.
REQ-014 IDLE: on an edge with frame_n=0, SHALL latch ad_in as address and cbe as command, then go to DECODE; otherwise stay.
REQ-015 Hit = BASE_ADDR <= addr < BASE_ADDR+DEPTH; miss SHALL return to IDLE with devsel_n, trdy_n and ad_oe left high/low-inactive (no claim).
REQ-016 DECODE, hit, write: SHALL assert devsel_n=0 and trdy_n=0 in the next cycle and enter DATA; word index = addr-BASE_ADDR.
REQ-017 DECODE, hit, read: SHALL assert devsel_n=0, keep trdy_n=1, enter TURN (one turnaround cycle, ad_oe=0).
REQ-018 TURN: SHALL set ad_oe=1, ad_out=mem[index], trdy_n=0 in the next cycle and enter DATA.
REQ-019 DATA: a phase completes on an edge with irdy_n=0 and trdy_n=0; write phase SHALL store ad_in into mem[index]; read phase SHALL advance ad_out to mem[index+1] for the next cycle.
REQ-020 Edge with irdy_n=1 SHALL hold index, ad_out and trdy_n (initiator wait state), no storage write.
REQ-021 Index SHALL increment by one per completed phase, wrapping DEPTH-1 -> 0.
REQ-022 Completed phase with frame_n=1 is the last; SHALL go to BACKOFF, deassert trdy_n, devsel_n and ad_oe next cycle.
REQ-023 frame_n=1 and irdy_n=1 in DATA (abort) SHALL go to BACKOFF with no storage write.
REQ-024 BACKOFF SHALL last exactly one cycle with all outputs inactive, then IDLE; a frame_n=0 there SHALL be ignored.
REQ-025 Storage SHALL be readable and writable only through bus transactions; unwritten words read as 0.

Reset
REQ-026 Reset SHALL force IDLE, devsel_n=1, trdy_n=1, ad_oe=0, ad_out=0, index=0, storage all zero.
REQ-027 Reset asserted mid-transaction SHALL take priority: outputs inactive on the next edge, pending write phase discarded.

Configuration
REQ-028 Macro PCI_TARGET_WAIT_EN defined: target SHALL insert one trdy_n=1 wait cycle before every data phase (after DECODE for write, after TURN for read, after each completed phase); index and ad_out held during it.
REQ-029 Macro undefined: zero target wait states, behaviour per REQ-016..REQ-022.

Structure
REQ-030 Package pci_pkg SHALL hold the target state enum, cbe encodings (CMD_READ=1, CMD_WRITE=0) and default DEPTH constant, shared with the initiator device.
REQ-031 Storage SHALL be a sub-module pci_target_mem (DEPTH x 32, one synchronous write port, one combinational read port, synchronous clear).

Verification
REQ-032 Write burst addr 0, data 32'hA0..32'hA3, frame_n high on 4th phase -> devsel_n/trdy_n low 4 phases, mem[0..3]=A0..A3, BACKOFF then IDLE.
REQ-033 Read burst addr 2 after REQ-032 -> one TURN cycle, ad_out=A2, A3, 0 on successive completed phases, ad_oe high only during DATA.
REQ-034 Address 32'h0000_0020 (miss) -> devsel_n stays 1 for whole frame, storage unchanged.
REQ-035 Write burst addr 9, data 1,2 -> mem[9]=1, mem[0]=2 (wrap).
REQ-036 irdy_n high for 2 cycles mid read burst -> ad_out and trdy_n held, no index skip; with PCI_TARGET_WAIT_EN, trdy_n toggles 1/0 each phase.
REQ-037 Reset asserted during DATA of a write -> next cycle all outputs inactive, IDLE, that phase's word not stored.
